ldm_stm_sequencer: RTL

- Multi-cycle sequencer for ARM block-transfer instructions (LDM/STM) in the datapath.
- On the register-file side, it is the counterpart of the register file's ports:
  - It drives the write port (we3/wa3/wd3) for loads.
  - It drives the read address (ra2) for stores.
- It walks the 16-bit register list in ascending order and performs one memory word transfer per set bit over a req/ack handshake. It then writes back the base register.
- The controller stalls the PC while busy=1.

---
 rtl/ldm_stm_sequencer_if.sv | 41 ++++
 rtl/ldm_stm_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_sequencer_if.sv
// Bus bundle between the LDM/STM sequencer and its environment: instruction
// fields, memory handshake, register-file ports and the PC load port.
interface ldm_stm_sequencer_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [15:0]      reglist;
  logic [3:0]       rn;
  logic [WIDTH-1:0] base;
  logic             l;
  logic             u;
  logic             p;
  logic             w;
  logic             busy;
  logic             done;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;
  logic [3:0]       rf_ra;
  logic [WIDTH-1:0] rf_rd;
  logic             rf_we;
  logic [3:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic             pc_we;
  logic [WIDTH-1:0] pc_wd;

  modport master (
    input  start, reglist, rn, base, l, u, p, w, mem_rdata, mem_ack, rf_rd,
    output busy, done, mem_req, mem_we, mem_addr, mem_wdata,
           rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
  );

  modport slave (
    output start, reglist, rn, base, l, u, p, w, mem_rdata, mem_ack, rf_rd,
    input  busy, done, mem_req, mem_we, mem_addr, mem_wdata,
           rf_ra, rf_we, rf_wa, rf_wd, pc_we, pc_wd
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer: walks the register list R0..R15, moves one
// word per set bit over a req/ack handshake, then optionally writes back Rn.
module ldm_stm_sequencer #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  ldm_stm_sequencer_if.master   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  function automatic logic [4:0] popcount16(input logic [15:0] bits);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, bits[i]};
    end
    return cnt;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] bits);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (bits[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [15:0]      list_q, list_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wbv_q, wbv_d;
  logic [3:0]       rn_q, rn_d;
  logic             l_q, l_d;
  logic             wb_en_q, wb_en_d;

  logic [4:0]       n_s;
  logic [WIDTH-1:0] span_s;
  logic [WIDTH-1:0] start_addr_s;
  logic [3:0]       cur_s;
  logic [15:0]      list_next_s;
  logic             xfer_s;
  logic             ack_s;

  assign n_s         = popcount16(bus.reglist);
  assign span_s      = WIDTH'(n_s) * STEP_W;
  assign cur_s       = lowest_set(list_q);
  assign list_next_s = list_q & ~(16'd1 << cur_s);
  assign xfer_s      = (state_q == S_XFER);
  // A reset pending in this cycle suppresses any write that would land on the edge.
  assign ack_s       = xfer_s & bus.mem_ack & ~reset_i;

  always_comb begin
    start_addr_s = bus.base;
    case ({bus.p, bus.u})
      2'b01:   start_addr_s = bus.base;
      2'b11:   start_addr_s = bus.base + STEP_W;
      2'b00:   start_addr_s = bus.base - span_s + STEP_W;
      2'b10:   start_addr_s = bus.base - span_s;
      default: start_addr_s = bus.base;
    endcase
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    wbv_d   = wbv_q;
    rn_d    = rn_q;
    l_d     = l_q;
    wb_en_d = wb_en_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          list_d  = bus.reglist;
          addr_d  = start_addr_s;
          wbv_d   = bus.u ? (bus.base + span_s) : (bus.base - span_s);
          rn_d    = bus.rn;
          l_d     = bus.l;
          // A load that includes Rn keeps the loaded value, not the writeback.
          wb_en_d = bus.w & ~(bus.l & bus.reglist[bus.rn]);
          state_d = (n_s == 5'd0) ? S_DONE : S_XFER;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (ack_s) begin
          list_d = list_next_s;
          addr_d = addr_q + STEP_W;
          if (list_next_s == 16'd0) begin
            state_d = wb_en_q ? S_WB : S_DONE;
          end else begin
            state_d = S_XFER;
          end
        end else begin
          state_d = S_XFER;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      list_q  <= 16'd0;
      addr_q  <= {WIDTH{1'b0}};
      wbv_q   <= {WIDTH{1'b0}};
      rn_q    <= 4'd0;
      l_q     <= 1'b0;
      wb_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      wbv_q   <= wbv_d;
      rn_q    <= rn_d;
      l_q     <= l_d;
      wb_en_q <= wb_en_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.mem_req   = xfer_s & ~reset_i;
    bus.mem_we    = xfer_s & ~l_q;
    bus.mem_addr  = xfer_s ? addr_q : {WIDTH{1'b0}};
    bus.mem_wdata = (xfer_s & ~l_q) ? bus.rf_rd : {WIDTH{1'b0}};
    bus.rf_ra     = xfer_s ? cur_s : 4'd0;
    bus.rf_we     = 1'b0;
    bus.rf_wa     = 4'd0;
    bus.rf_wd     = {WIDTH{1'b0}};
    bus.pc_we     = 1'b0;
    bus.pc_wd     = {WIDTH{1'b0}};
    if (ack_s && l_q) begin
      // R15 goes to the PC port directly instead of the register file.
      if (cur_s == 4'd15) begin
        bus.pc_we = 1'b1;
        bus.pc_wd = bus.mem_rdata;
      end else begin
        bus.rf_we = 1'b1;
        bus.rf_wa = cur_s;
        bus.rf_wd = bus.mem_rdata;
      end
    end else if ((state_q == S_WB) && !reset_i) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = rn_q;
      bus.rf_wd = wbv_q;
    end else begin
      bus.rf_we = 1'b0;
    end
  end

endmodule
